// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: a pipeline stage register with a valid/ready handshake on both
// sides and a one-entry skid buffer. The skid buffer lets in_ready be driven
// purely from a flop (gated only by reset), so out_ready never reaches in_ready
// combinationally. Full throughput of one transfer per cycle is kept.
//
// State is carried by the two valid flops {main_v, skid_v}:
//   EMPTY = 00, ONE = 10, TWO = 11. The pattern 01 is unreachable.
// The main register always drives out/out_valid. The skid register only holds
// the second entry, which arrives while the main entry is stalled.
// Flush and reset clear both valid bits. Flush leaves the data registers
// unchanged. Reset loads RST_VAL into both data registers.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_e;

  // Control flops: the state is encoded directly in the two valid bits
  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;

  // Data flops
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  state_e state;
  logic   acc;
  logic   pop;

  assign state = state_e'({main_v_q, skid_v_q});

  // Output decode: in_ready depends only on the skid flop and reset
  always_comb begin
    in_ready  = rst & ~skid_v_q;
    out_valid = main_v_q;
    out       = main_q;
  end

  assign acc = in_valid & in_ready;
  assign pop = main_v_q & out_ready;

  // Next-state logic for the valid bits; flush overrides any handshake
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) main_v_d = 1'b1;
        end
        ONE: begin
          if (acc && !pop) skid_v_d = 1'b1;
          else if (!acc && pop) main_v_d = 1'b0;
        end
        TWO: begin
          // in_ready is low here, so only a pop can move the state
          if (pop) skid_v_d = 1'b0;
        end
        default: begin
          // 01 is unreachable; fall back to EMPTY if it ever appears
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  // Data register loads; writes happen only on the listed transitions
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      unique case (state)
        EMPTY: begin
          if (acc) main_d = in;
        end
        ONE: begin
          if (acc && pop) main_d = in;
          else if (acc && !pop) skid_d = in;
        end
        TWO: begin
          if (pop) main_d = skid_q;
        end
        default: begin
          main_d = main_q;
        end
      endcase
    end
  end

  // State and data registers; the active-low synchronous reset has priority
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= RST_VAL;
      skid_q   <= RST_VAL;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed testbench for pipe_skid_reg: reset, a single transfer,
// backpressure through the skid buffer, streaming, flush and mid-run reset.
module tb_pipe_skid_reg;

  localparam int unsigned      WIDTH = 32;
  localparam logic [WIDTH-1:0] RV    = 32'hA5A5_5A5A;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;

  int errors;
  int checks;

  pipe_skid_reg #(.WIDTH(WIDTH), .RST_VAL(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so outputs are stable to sample
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in = '0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out !== RV) begin
      errors++; $display("FAIL reset_out: got %h want %h", out, RV);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in = 32'hBABEFACE; in_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_no_early: got v=%b want 0", out_valid);
    end
    tick();
    in_valid = 1'b0; in = 32'h0;
    checks++;
    if (out_valid !== 1'b1 || out !== 32'hBABEFACE) begin
      errors++; $display("FAIL single_out: got v=%b d=%h want v=1 d=babeface", out_valid, out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in = 32'hBABEFACE; in_valid = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_in_one: got %b want 1", in_ready);
    end
    in = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0; in = 32'h0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_in_two: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 32'hBABEFACE || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got v=%b d=%h r=%b want v=1 d=babeface r=0", out_valid, out, in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bp_second: got v=%b d=%h want v=1 d=deadbeef", out_valid, out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_back: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in = WIDTH'(i); in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out !== WIDTH'(i)) begin
        errors++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out, WIDTH'(i));
      end
    end
    in_valid = 1'b0; in = 32'h0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in = 32'h1111AAAA; in_valid = 1'b1;
    tick();
    in = 32'h2222BBBB;
    tick();
    in = 32'h3333CCCC; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; in = 32'h0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_two: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    checks++;
    if (out !== 32'h1111AAAA) begin
      errors++; $display("FAIL flush_data_hold: got %h want 1111aaaa", out);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out === 32'h3333CCCC) begin
        errors++; $display("FAIL flush_no_c[%0d]: got v=%b d=%h want v=0 d!=3333cccc", k, out_valid, out);
      end
    end
    // Flush with a same-cycle accept from EMPTY: the accept is discarded
    in = 32'h4444DDDD; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; in = 32'h0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop_acc: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in = 32'h12345678; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in = 32'h0;
    checks++;
    if (out_valid !== 1'b1 || out !== 32'h12345678) begin
      errors++; $display("FAIL mid_loaded: got v=%b d=%h want v=1 d=12345678", out_valid, out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_ready_in_reset: got %b want 0", in_ready);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== RV || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_after_reset: got v=%b d=%h r=%b want v=0 d=%h r=1", out_valid, out, in_ready, RV);
    end
    out_ready = 1'b1;
    in = 32'hCAFEF00D; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in = 32'h0;
    checks++;
    if (out_valid !== 1'b1 || out !== 32'hCAFEF00D) begin
      errors++; $display("FAIL mid_transfer: got v=%b d=%h want v=1 d=cafef00d", out_valid, out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_drain: got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in = '0;
    #2;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
